fp32_accumulator: RTL and testbench

FP32_ACCUMULATOR -- requirements
Module: fp32_accumulator

---
 rtl/fp32_accumulator.sv | 269 ++++++++++++++++++++++++++
 tb/tb_fp32_accumulator.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fp32_accumulator.sv
// Sequential IEEE-754 binary32 accumulator for dot-product terms.
// One term every five cycles through ALIGN/ADD/NORM/ROUND; round-to-nearest-even, with NaN/Inf handling.
module fp32_accumulator #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);

    // Handshake rule for both ports: a transfer happens on a rising edge where valid && ready;
    // the source holds its data until then, and ready never depends on valid.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        ROUND = 3'd4,
        OUT   = 3'd5
    } state_t;

    localparam logic [31:0] CANON_NAN = 32'hFFC00000;

    state_t state, next_state;

    logic             armed;
    logic [31:0]      acc;
    logic [31:0]      term;
    logic             term_last;
    logic             term_first;
    logic [CNT_W-1:0] count;

    logic [26:0]       x_m, y_m;
    logic              x_s, y_s;
    logic signed [9:0] big_e;
    logic              spec;
    logic [31:0]       spec_val;

    logic [27:0]       sum_m;
    logic              sum_s;

    logic [26:0]       nrm_m;
    logic signed [9:0] nrm_e;

    logic accept;
    assign accept = in_valid && in_ready;

    // ---------------- ALIGN: unpack and align the smaller operand ----------------
    logic [7:0]        a_ef, b_ef;
    logic [22:0]       a_f, b_f;
    logic              a_s, b_s;
    logic signed [9:0] a_e, b_e, d;
    logic [26:0]       a_m, b_m, sm_m, al_m;
    logic [53:0]       wide;
    logic              a_nan, b_nan, a_inf, b_inf, swap;
    logic              spec_n;
    logic [31:0]       spec_val_n;

    always_comb begin
        a_ef = acc[30:23];
        a_f  = acc[22:0];
        b_ef = term[30:23];
        b_f  = term[22:0];
        // An empty accumulator takes the term's sign so a lone -0 survives.
        a_s  = term_first ? term[31] : acc[31];
        b_s  = term[31];
        a_e  = (a_ef == 8'd0) ? -10'sd126 : $signed({2'b00, a_ef}) - 10'sd127;
        b_e  = (b_ef == 8'd0) ? -10'sd126 : $signed({2'b00, b_ef}) - 10'sd127;
        a_m  = {(a_ef != 8'd0), a_f, 3'b000};
        b_m  = {(b_ef != 8'd0), b_f, 3'b000};
        a_nan = (&a_ef) && (|a_f);
        b_nan = (&b_ef) && (|b_f);
        a_inf = (&a_ef) && !(|a_f);
        b_inf = (&b_ef) && !(|b_f);

        swap = (b_e > a_e);
        sm_m = swap ? a_m : b_m;
        d    = swap ? (b_e - a_e) : (a_e - b_e);
        wide = '0;
        if (d >= 10'sd27) begin
            al_m = {26'd0, |sm_m};
        end else begin
            wide = {sm_m, 27'd0} >> d[4:0];
            al_m = {wide[53:28], wide[27] | (|wide[26:0])};
        end

        spec_n     = 1'b1;
        spec_val_n = CANON_NAN;
        if (a_nan || b_nan) begin
            spec_val_n = CANON_NAN;
        end else if (a_inf && b_inf && (a_s != b_s)) begin
            spec_val_n = CANON_NAN;
        end else if (a_inf) begin
            spec_val_n = {a_s, acc[30:0]};
        end else if (b_inf) begin
            spec_val_n = term;
        end else begin
            spec_n = 1'b0;
        end
    end

    // ---------------- ADD: signed-magnitude add ----------------
    logic [27:0] sum_m_n;
    logic        sum_s_n;

    always_comb begin
        if (x_s == y_s) begin
            sum_m_n = {1'b0, x_m} + {1'b0, y_m};
            sum_s_n = x_s;
        end else if (x_m >= y_m) begin
            sum_m_n = {1'b0, x_m} - {1'b0, y_m};
            sum_s_n = (x_m == y_m) ? 1'b0 : x_s;
        end else begin
            sum_m_n = {1'b0, y_m} - {1'b0, x_m};
            sum_s_n = y_s;
        end
    end

    // ---------------- NORM: carry shift or bounded left shift ----------------
    logic [4:0]        lzc, sh;
    logic signed [9:0] limit;
    logic [26:0]       nrm_m_n;
    logic signed [9:0] nrm_e_n;

    always_comb begin
        lzc = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (sum_m[i]) lzc = 5'(26 - i);
        end
        // Never shift below exponent -126; what remains is a denormal.
        limit = big_e + 10'sd126;
        if ({5'd0, lzc} > $unsigned(limit)) sh = limit[4:0];
        else                                sh = lzc;
        if (sum_m[27]) begin
            nrm_m_n = {sum_m[27:2], sum_m[1] | sum_m[0]};
            nrm_e_n = big_e + 10'sd1;
        end else begin
            nrm_m_n = sum_m[26:0] << sh;
            nrm_e_n = big_e - $signed({5'd0, sh});
        end
    end

    // ---------------- ROUND: nearest-even and repack ----------------
    logic              rnd_up;
    logic [24:0]       r25;
    logic [23:0]       r_mant;
    logic signed [9:0] r_e, biased;
    logic [31:0]       result;

    always_comb begin
        rnd_up = nrm_m[2] && (nrm_m[1] || nrm_m[0] || nrm_m[3]);
        r25    = {1'b0, nrm_m[26:3]} + {24'd0, rnd_up};
        if (r25[24]) begin
            r_mant = r25[24:1];
            r_e    = nrm_e + 10'sd1;
        end else begin
            r_mant = r25[23:0];
            r_e    = nrm_e;
        end
        biased = r_e + 10'sd127;
        if (spec) begin
            result = spec_val;
        end else if (!r_mant[23]) begin
            result = {sum_s, 8'd0, r_mant[22:0]};
        end else if (biased >= 10'sd255) begin
            result = {sum_s, 8'hFF, 23'd0};
        end else begin
            result = {sum_s, biased[7:0], r_mant[22:0]};
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = ALIGN;
            ALIGN:   next_state = ADD;
            ADD:     next_state = NORM;
            NORM:    next_state = ROUND;
            ROUND:   next_state = term_last ? OUT : IDLE;
            OUT:     if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = armed && (state == IDLE);
        out_valid = (state == OUT);
        busy      = (state != IDLE);
        out_data  = out_valid ? acc : 32'd0;
        out_count = out_valid ? count : '0;
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed      <= 1'b0;
            acc        <= 32'd0;
            term       <= 32'd0;
            term_last  <= 1'b0;
            term_first <= 1'b0;
            count      <= '0;
            x_m        <= '0;
            y_m        <= '0;
            x_s        <= 1'b0;
            y_s        <= 1'b0;
            big_e      <= '0;
            spec       <= 1'b0;
            spec_val   <= 32'd0;
            sum_m      <= '0;
            sum_s      <= 1'b0;
            nrm_m      <= '0;
            nrm_e      <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        term       <= in_data;
                        term_last  <= in_last;
                        term_first <= (count == '0);
                        count      <= (&count) ? count : count + 1'b1;
                    end
                end
                ALIGN: begin
                    x_m      <= swap ? b_m : a_m;
                    x_s      <= swap ? b_s : a_s;
                    y_m      <= al_m;
                    y_s      <= swap ? a_s : b_s;
                    big_e    <= swap ? b_e : a_e;
                    spec     <= spec_n;
                    spec_val <= spec_val_n;
                end
                ADD: begin
                    sum_m <= sum_m_n;
                    sum_s <= sum_s_n;
                end
                NORM: begin
                    nrm_m <= nrm_m_n;
                    nrm_e <= nrm_e_n;
                end
                ROUND: begin
                    acc <= result;
                end
                OUT: begin
                    if (out_ready) begin
                        acc   <= 32'd0;
                        count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_accumulator.sv
// Directed bench for fp32_accumulator: vector table of term groups with hand-computed sums,
// plus sequences for issue timing, output back-pressure and mid-operation reset.
module tb_fp32_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [15:0] out_count;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [15:0] cnt_q[$];

    typedef struct packed {
        logic [1:0]  n;
        logic [31:0] t0;
        logic [31:0] t1;
        logic [31:0] t2;
        logic [31:0] exp_data;
        logic [15:0] exp_cnt;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    fp32_accumulator #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .busy      (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- drivers (called at a negedge) ----------------
    task automatic send_term(input logic [31:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
        in_last  = 1'($urandom_range(0, 1));
    endtask

    task automatic get_result(input string name);
        int n = 0;
        logic [31:0] ed;
        logic [15:0] ec;
        ed = exp_q.pop_front();
        ec = cnt_q.pop_front();
        out_ready = 1'b1;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            check({name, "_timeout"}, 64'(out_valid), 64'd1);
        end else begin
            check({name, "_data"}, 64'(out_data), 64'(ed));
            check({name, "_count"}, 64'(out_count), 64'(ec));
            @(posedge clk);
            @(negedge clk);
            check({name, "_ready_after"}, 64'({in_ready, out_valid}), 64'b10);
        end
    endtask

    task automatic expect_result(input logic [31:0] d, input logic [15:0] c);
        exp_q.push_back(d);
        cnt_q.push_back(c);
    endtask

    // ---------------- test ----------------
    initial begin
        int k;
        vecs[0]  = '{2'd2, 32'h3F800000, 32'h40000000, 32'h0, 32'h40400000, 16'd2}; // 1+2
        vecs[1]  = '{2'd2, 32'h3F800000, 32'h33800000, 32'h0, 32'h3F800000, 16'd2}; // tie, even
        vecs[2]  = '{2'd2, 32'h3F800000, 32'hBF800000, 32'h0, 32'h00000000, 16'd2}; // cancel to +0
        vecs[3]  = '{2'd2, 32'h7F800000, 32'hFF800000, 32'h0, 32'hFFC00000, 16'd2}; // inf-inf
        vecs[4]  = '{2'd2, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0, 32'h7F800000, 16'd2}; // overflow
        vecs[5]  = '{2'd2, 32'h00000001, 32'h00000001, 32'h0, 32'h00000002, 16'd2}; // denormals
        vecs[6]  = '{2'd1, 32'h80000000, 32'h0, 32'h0, 32'h80000000, 16'd1};        // lone -0
        vecs[7]  = '{2'd2, 32'h80000000, 32'h80000000, 32'h0, 32'h80000000, 16'd2}; // -0 + -0
        vecs[8]  = '{2'd2, 32'h7F800001, 32'h3F800000, 32'h0, 32'hFFC00000, 16'd2}; // NaN in
        vecs[9]  = '{2'd2, 32'h7F800000, 32'hC0000000, 32'h0, 32'h7F800000, 16'd2}; // inf+finite
        vecs[10] = '{2'd2, 32'h3F800000, 32'h33800001, 32'h0, 32'h3F800001, 16'd2}; // above half
        vecs[11] = '{2'd2, 32'h3F800001, 32'h33800000, 32'h0, 32'h3F800002, 16'd2}; // tie, odd up
        vecs[12] = '{2'd2, 32'h40400000, 32'hC0000000, 32'h0, 32'h3F800000, 16'd2}; // 3-2 normalise
        vecs[13] = '{2'd3, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40400000, 16'd3};
        vecs[14] = '{2'd2, 32'h00400000, 32'h00400000, 32'h0, 32'h00800000, 16'd2}; // denorm->norm
        vecs[15] = '{2'd2, 32'h00800000, 32'h80000001, 32'h0, 32'h007FFFFF, 16'd2}; // norm->denorm
        vecs[16] = '{2'd2, 32'hBF800000, 32'hC0000000, 32'h0, 32'hC0400000, 16'd2}; // -1 + -2
        vecs[17] = '{2'd2, 32'h4F800000, 32'h3F800000, 32'h0, 32'h4F800000, 16'd2}; // shift >= 27

        // Reset state, checked asynchronously before any clock edge.
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #1;
        check("reset_outputs", {in_ready, out_valid, out_data, out_count, busy}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_before_edge", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("ready_after_reset", 64'(in_ready), 64'd1);

        // Issue timing: next in_ready five cycles after an accept.
        send_term(32'h3F800000, 1'b0);
        check("busy_in_align", 64'(busy), 64'd1);
        k = 1;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("issue_interval", 64'(k), 64'd5);
        send_term(32'h40000000, 1'b1);
        expect_result(32'h40400000, 16'd2);
        get_result("timing_sum");

        // Table of term groups.
        for (int i = 0; i < NV; i++) begin
            for (int j = 0; j < int'(vecs[i].n); j++) begin
                send_term((j == 0) ? vecs[i].t0 : (j == 1) ? vecs[i].t1 : vecs[i].t2,
                          (j == int'(vecs[i].n) - 1));
            end
            expect_result(vecs[i].exp_data, vecs[i].exp_cnt);
            get_result($sformatf("vec%0d", i));
        end

        // Back-pressure: result held stable while out_ready is low.
        out_ready = 1'b0;
        send_term(32'h3F800000, 1'b0);
        send_term(32'h40000000, 1'b1);
        k = 0;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        for (int c = 0; c < 5; c++) begin
            check($sformatf("stall%0d", c), {out_valid, in_ready, out_count, out_data},
                  {1'b1, 1'b0, 16'd2, 32'h40400000});
            @(negedge clk);
        end
        expect_result(32'h40400000, 16'd2);
        get_result("stall_release");
        send_term(32'h40000000, 1'b1);
        expect_result(32'h40000000, 16'd1);
        get_result("after_stall");

        // Reset during ADD discards the partial sum.
        send_term(32'h3F800000, 1'b0);
        @(negedge clk);
        check("busy_in_add", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_reset_outputs", {in_ready, out_valid, out_data, out_count, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_mid_reset", 64'(in_ready), 64'd1);
        send_term(32'h40000000, 1'b1);
        expect_result(32'h40000000, 16'd1);
        get_result("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
